uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter c_clkfreq, default 100_000_000, meaning system clock frequency in Hz.
REQ-002 Parameter c_baudrate, default 115_200, meaning serial bit rate in baud.
REQ-003 Port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 Port rst_n_i  input  1  reset; synchronous and active-low.
REQ-005 Port rx_i  input  1  serial line; idle high; asynchronous to clk.
REQ-006 Port dout_o  output  8  last correctly received data byte.
REQ-007 Port rx_done_tick_o  output  1  one-cycle pulse when dout_o has been updated with a new byte.
REQ-008 Port order SHALL be clk, rx_i, dout_o, rx_done_tick_o, rst_n_i, so that existing positional instantiations of the first four ports remain valid.

Function
REQ-009 Frame format SHALL be 1 start bit (low), 8 data bits LSB first, 1 stop bit (high), no parity.
REQ-010 The bit-timer limit SHALL be c_bittimerlim = c_clkfreq / c_baudrate, using integer division (868 at defaults); the timer width SHALL be sized from this value.
REQ-011 rx_i SHALL pass through a 2-flop synchronizer; both flops SHALL reset to 1; all decoding SHALL use the synchronized value.
REQ-012 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-013 IDLE: timer held at 0; when the synchronized rx is 0, go to START.
REQ-014 START: the timer counts to c_bittimerlim/2-1 (mid start bit), then checks rx: if 0, clear the timer and go to DATA; if 1 (glitch), go to IDLE with no output change.
REQ-015 DATA: the timer counts to c_bittimerlim-1, then clears; at each expiry rx is shifted into the MSB of an 8-bit shift register (right shift); after the 8th sample, go to STOP.
REQ-016 STOP: the timer counts to c_bittimerlim-1; at expiry (mid stop bit), load dout_o from the shift register, pulse rx_done_tick_o for exactly one cycle, and go to IDLE.
REQ-017 rx_done_tick_o SHALL rise 9.5 bit periods after the falling edge of the start bit, within +/-4 clk (approx. 8246 cycles at defaults).
REQ-018 dout_o SHALL hold its value between frames; it changes only in the cycle rx_done_tick_o is high.
REQ-019 Because it returns to IDLE at mid stop bit, the receiver SHALL accept a start bit that immediately follows the stop bit (back-to-back frames).
REQ-020 A low rx in IDLE SHALL always start a frame; no break detection.

Reset
REQ-021 When rst_n_i=0 at a clock edge: state=IDLE, timer=0, bit counter=0, shift register=0x00, dout_o=0x00, rx_done_tick_o=0, synchronizer flops=1.
REQ-022 Reset mid-frame SHALL abort the frame with no tick; the next falling edge after release starts a new frame.

Configuration
REQ-023 Macro UART_RX_FRAME_ERR_EN: when defined, add output port frame_err_o (1 bit, reset 0, placed last).
REQ-024 With the macro defined, if the stop bit samples 0, frame_err_o SHALL pulse one cycle, rx_done_tick_o SHALL stay 0, and dout_o SHALL be unchanged.
REQ-025 Without the macro, the stop-bit value SHALL be ignored: rx_done_tick_o pulses and dout_o loads regardless, and the port is absent.

Verification
REQ-026 Reset, then frame 0x52 at 8680 ns/bit (10-bit pattern 1_01010010_0, sent LSB-first) -> one rx_done_tick_o pulse and dout_o=0x52.
REQ-027 Wait 20 us, send 0xB5 -> one tick and dout_o=0xB5; wait 20 us, send 0x55 -> one tick and dout_o=0x55; no ticks between frames.
REQ-028 Pull rx_i low for 2 us, then high -> no tick, dout_o unchanged; the next valid frame 0xA3 is received correctly.
REQ-029 Assert rst_n_i during bit 4 of a 0xFF frame -> no tick and dout_o=0x00; a following 0x3C frame -> dout_o=0x3C.
REQ-030 Send 0x81 and 0x7E back-to-back with no idle gap -> two ticks with dout_o 0x81 then 0x7E; tick timing within REQ-017 tolerance.
REQ-031 With UART_RX_FRAME_ERR_EN defined, send 0x52 with stop bit 0 -> frame_err_o pulse, no tick, dout_o keeps its previous value.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver
//
// Receives frames of 1 start bit (low), 8 data bits LSB first and 1 stop bit
// (high), no parity. The serial input is brought into the clk domain through
// a 2-flop synchronizer. Every bit is sampled once, at its midpoint, by a
// bit timer that runs at the system clock.
//
// Parameters
//   c_clkfreq       system clock frequency in Hz
//   c_baudrate      serial bit rate in baud
//
// Ports
//   clk             system clock; all logic runs on its rising edge
//   rx_i            serial line, idle high, asynchronous to clk
//   dout_o          last correctly received data byte
//   rx_done_tick_o  one-cycle pulse in the cycle dout_o shows a new byte
//   rst_n_i         synchronous active-low reset
//   frame_err_o     (only with UART_RX_FRAME_ERR_EN) one-cycle pulse when the
//                   stop bit is sampled low; the byte is then discarded
//
// Build option
//   UART_RX_FRAME_ERR_EN  when defined, adds frame_err_o and drops frames
//                         whose stop bit samples low. When undefined, the
//                         stop-bit value is ignored.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int c_clkfreq  = 100_000_000,
  parameter int c_baudrate = 115_200
) (
  input  logic       clk,
  input  logic       rx_i,
  output logic [7:0] dout_o,
  output logic       rx_done_tick_o,
  input  logic       rst_n_i
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_err_o
`endif
);

  // Clock cycles per bit (integer division, 868 at the default values)
  localparam int c_bittimerlim = c_clkfreq / c_baudrate;
  localparam int c_timer_w     = $clog2(c_bittimerlim + 1);

  typedef logic [c_timer_w-1:0] timer_t;

  // Terminal counts: the half value finds mid start bit, the full value then
  // steps from one bit midpoint to the next.
  localparam timer_t c_half_last = timer_t'(c_bittimerlim / 2 - 1);
  localparam timer_t c_full_last = timer_t'(c_bittimerlim - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // 2-flop synchronizer; resets to the idle line level so that reset itself
  // cannot look like a start bit.
  logic [1:0] sync_reg;
  logic       rx_sync;

  state_t     state_reg,   state_next;
  timer_t     timer_reg,   timer_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shreg_reg,   shreg_next;
  logic [7:0] dout_reg,    dout_next;
  logic       tick_reg,    tick_next;
`ifdef UART_RX_FRAME_ERR_EN
  logic       err_reg,     err_next;
`endif

  assign rx_sync = sync_reg[1];

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      sync_reg    <= 2'b11;
      state_reg   <= IDLE;
      timer_reg   <= '0;
      bit_cnt_reg <= '0;
      shreg_reg   <= '0;
      dout_reg    <= '0;
      tick_reg    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      err_reg     <= 1'b0;
`endif
    end else begin
      sync_reg    <= {sync_reg[0], rx_i};
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      bit_cnt_reg <= bit_cnt_next;
      shreg_reg   <= shreg_next;
      dout_reg    <= dout_next;
      tick_reg    <= tick_next;
`ifdef UART_RX_FRAME_ERR_EN
      err_reg     <= err_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    bit_cnt_next = bit_cnt_reg;
    shreg_next   = shreg_reg;
    dout_next    = dout_reg;
    tick_next    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    err_next     = 1'b0;
`endif

    case (state_reg)
      IDLE: begin
        timer_next = '0;
        // Any low level starts a frame; there is no break detection.
        if (!rx_sync) begin
          state_next = START;
        end
      end

      START: begin
        if (timer_reg == c_half_last) begin
          timer_next = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_next = rx_sync ? IDLE : DATA;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      DATA: begin
        if (timer_reg == c_full_last) begin
          timer_next = '0;
          // LSB arrives first, so shifting right leaves bit 0 in place.
          shreg_next = {rx_sync, shreg_reg[7:1]};
          if (bit_cnt_reg == 3'd7) begin
            bit_cnt_next = '0;
            state_next   = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
          end
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      STOP: begin
        // Leaving at mid stop bit gives half a bit of slack to catch a start
        // bit that follows immediately.
        if (timer_reg == c_full_last) begin
          timer_next = '0;
          state_next = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_sync) begin
            dout_next = shreg_reg;
            tick_next = 1'b1;
          end else begin
            err_next  = 1'b1;
          end
`else
          dout_next = shreg_reg;
          tick_next = 1'b1;
`endif
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  assign dout_o         = dout_reg;
  assign rx_done_tick_o = tick_reg;
`ifdef UART_RX_FRAME_ERR_EN
  assign frame_err_o    = err_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx
//
// The DUT runs from a 10 MHz clock so that a full run stays short; the line
// is driven at 8680 ns per bit. The reference model is simply "each well
// formed frame yields exactly one tick carrying the byte that was sent,
// 9.5 DUT bit periods after the start edge, within +/-4 clocks".
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int  CLKFREQ = 10_000_000;
  localparam int  BAUD    = 115_200;
  localparam int  LIM     = CLKFREQ / BAUD;
  localparam int  CLK_NS  = 100;
  localparam int  BIT_NS  = 8680;
  localparam longint EXP_NS = longint'(LIM / 2 + 9 * LIM) * CLK_NS;
  localparam longint TOL_NS = 4 * CLK_NS;

  logic       clk   = 1'b0;
  logic       rx    = 1'b1;
  logic       rst_n = 1'b0;
  logic [7:0] dout;
  logic       tick;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] tick_q[$];
  longint     tick_t[$];
  int         err_cnt    = 0;
  int         dout_bad   = 0;
  logic [7:0] prev_dout  = 8'h00;
  logic [7:0] last_byte  = 8'h00;

  uart_rx #(
    .c_clkfreq  (CLKFREQ),
    .c_baudrate (BAUD)
  ) dut (
    .clk            (clk),
    .rx_i           (rx),
    .dout_o         (dout),
    .rx_done_tick_o (tick),
    .rst_n_i        (rst_n)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err_o    (frame_err)
`endif
  );

  always #(CLK_NS / 2) clk = ~clk;

  // Observe outputs on the falling edge; record every tick with its rise time.
  always @(negedge clk) begin
    if (tick === 1'b1) begin
      tick_q.push_back(dout);
      tick_t.push_back($time - CLK_NS / 2);
    end
`ifdef UART_RX_FRAME_ERR_EN
    if (frame_err === 1'b1) err_cnt++;
`endif
    if (rst_n === 1'b1 && tick !== 1'b1 && dout !== prev_dout) dout_bad++;
    prev_dout = dout;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, output longint t0);
    @(negedge clk);
    rx = 1'b0;
    t0 = $time;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    if (stop_ok) begin
      rx = 1'b1;
      #(BIT_NS);
    end else begin
      // Low long enough to cover mid stop bit, then back to idle.
      rx = 1'b0;
      #(BIT_NS * 6 / 10);
      rx = 1'b1;
      #(BIT_NS * 4 / 10);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] b, input longint t0, input int n0);
    longint dt;
    bit     in_win;
    check({tag, "_ticks"}, 32'(tick_q.size()), 32'(n0 + 1));
    if (tick_q.size() == n0 + 1) begin
      check({tag, "_data"}, 32'(tick_q[n0]), 32'(b));
      dt     = tick_t[n0] - t0;
      in_win = (dt >= EXP_NS - TOL_NS) && (dt <= EXP_NS + TOL_NS);
      check({tag, "_timing"}, 32'(in_win), 32'd1);
    end
    check({tag, "_dout"}, 32'(dout), 32'(b));
    last_byte = b;
    $display("frame %s byte=%02h ticks=%0d dout=%02h", tag, b, tick_q.size() - n0, dout);
  endtask

  initial begin
    longint t0;
    int     n0;
    int     e0;
    logic [7:0] b;
    int     gap;

    // Reset
    repeat (4) @(negedge clk);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_tick", 32'(tick), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Basic frames with idle gaps
    n0 = tick_q.size(); send_frame(8'h52, 1'b1, t0); expect_frame("f52", 8'h52, t0, n0);
    #20000;
    n0 = tick_q.size(); send_frame(8'hB5, 1'b1, t0); expect_frame("fB5", 8'hB5, t0, n0);
    #20000;
    n0 = tick_q.size(); send_frame(8'h55, 1'b1, t0); expect_frame("f55", 8'h55, t0, n0);

    // Short low glitch must not start a frame
    n0 = tick_q.size();
    @(negedge clk); rx = 1'b0; #2000; rx = 1'b1; #20000;
    check("glitch_ticks", 32'(tick_q.size()), 32'(n0));
    check("glitch_dout", 32'(dout), 32'(last_byte));
    $display("glitch ticks=%0d dout=%02h", tick_q.size() - n0, dout);
    n0 = tick_q.size(); send_frame(8'hA3, 1'b1, t0); expect_frame("fA3", 8'hA3, t0, n0);

    // Reset during bit 4 of a 0xFF frame
    n0 = tick_q.size();
    @(negedge clk); rx = 1'b0; #(BIT_NS);
    rx = 1'b1; #(BIT_NS * 4 + BIT_NS / 2);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #(BIT_NS * 6);
    check("rstmid_ticks", 32'(tick_q.size()), 32'(n0));
    check("rstmid_dout", 32'(dout), 32'h00);
    $display("reset mid-frame ticks=%0d dout=%02h", tick_q.size() - n0, dout);
    n0 = tick_q.size(); send_frame(8'h3C, 1'b1, t0); expect_frame("f3C", 8'h3C, t0, n0);

    // Back-to-back frames
    #20000;
    n0 = tick_q.size(); send_frame(8'h81, 1'b1, t0); expect_frame("b2b81", 8'h81, t0, n0);
    n0 = tick_q.size(); send_frame(8'h7E, 1'b1, t0); expect_frame("b2b7E", 8'h7E, t0, n0);

    // Random bytes with random gaps (zero gap is back-to-back)
    for (int k = 0; k < 8; k++) begin
      b   = 8'($urandom);
      gap = $urandom_range(0, 2);
      #(gap * BIT_NS);
      n0 = tick_q.size(); send_frame(b, 1'b1, t0); expect_frame("rand", b, t0, n0);
    end

    // Stop bit sampled low
    #20000;
    n0 = tick_q.size();
    e0 = err_cnt;
`ifdef UART_RX_FRAME_ERR_EN
    send_frame(8'h52, 1'b0, t0);
    #(BIT_NS * 3);
    check("ferr_ticks", 32'(tick_q.size()), 32'(n0));
    check("ferr_pulse", 32'(err_cnt), 32'(e0 + 1));
    check("ferr_dout", 32'(dout), 32'(last_byte));
    $display("frame error ticks=%0d err=%0d dout=%02h", tick_q.size() - n0, err_cnt - e0, dout);
`else
    send_frame(8'h52, 1'b0, t0);
    expect_frame("badstop", 8'h52, t0, n0);
    #(BIT_NS * 3);
    check("badstop_after", 32'(tick_q.size()), 32'(n0 + 1));
    check("badstop_err", 32'(err_cnt), 32'(e0));
`endif

    check("dout_stable", 32'(dout_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
